// File: rtl/rvfi_pc_chain_pkg.sv
// Shared types for the RVFI PC-chain continuity checker.
// Optional trap/interrupt exemption: RVFI_PC_CHAIN_TRAP_SKIP_EN.
package rvfi_pc_chain_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE,
    FAIL
  } chain_state_e;

  localparam int DEPTH_MAX = 16;

  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/rvfi_pc_chain_capture.sv
// Per-channel window match: offset, range check, slot select, duplicates.
// Trap/intr data is always routed; the top decides whether to keep it.
module rvfi_pc_chain_capture
  import rvfi_pc_chain_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NRET  = 1,
  parameter int DEPTH = 4,
  parameter int IW    = idx_w(DEPTH)
) (
  input  logic                           en,
  input  logic [63:0]                    base,
  input  logic [DEPTH-1:0]               slot_vld,
  input  logic [NRET-1:0]                valid,
  input  logic [64*NRET-1:0]             order,
  input  logic [XLEN*NRET-1:0]           rdata,
  input  logic [XLEN*NRET-1:0]           wdata,
  input  logic [NRET-1:0]                trap,
  input  logic [NRET-1:0]                intr,
  output logic [DEPTH-1:0]               we,
  output logic [DEPTH-1:0][XLEN-1:0]     wr_rdata,
  output logic [DEPTH-1:0][XLEN-1:0]     wr_wdata,
  output logic [DEPTH-1:0]               wr_trap,
  output logic [DEPTH-1:0]               wr_intr,
  output logic                           dup,
  output logic [IW-1:0]                  dup_idx
);

  logic [NRET-1:0][63:0] off;
  logic [NRET-1:0]       inw;
  logic [DEPTH-1:0]      multi;
  logic [DEPTH-1:0]      dslot;

  always_comb begin
    we       = '0;
    multi    = '0;
    wr_rdata = '0;
    wr_wdata = '0;
    wr_trap  = '0;
    wr_intr  = '0;
    off      = '0;
    inw      = '0;
    for (int c = 0; c < NRET; c++) begin
      // Modulo-2^64 difference keeps windows across the wrap legal
      off[c] = order[64*c +: 64] - base;
      inw[c] = en && valid[c] && (off[c] < 64'(DEPTH));
      for (int s = 0; s < DEPTH; s++) begin
        if (inw[c] && off[c] == 64'(s)) begin
          multi[s]    = multi[s] | we[s];
          we[s]       = 1'b1;
          wr_rdata[s] = rdata[XLEN*c +: XLEN];
          wr_wdata[s] = wdata[XLEN*c +: XLEN];
          wr_trap[s]  = trap[c];
          wr_intr[s]  = intr[c];
        end
      end
    end
    dslot   = we & (slot_vld | multi);
    dup     = |dslot;
    dup_idx = '0;
    for (int s = DEPTH - 1; s >= 0; s--) begin
      if (dslot[s]) dup_idx = IW'(s);
    end
  end

endmodule

// File: rtl/rvfi_pc_chain_check.sv
// Multi-retire PC-continuity checker over a window of DEPTH orders.
// Define RVFI_PC_CHAIN_TRAP_SKIP_EN to exempt pairs around traps/interrupts.
module rvfi_pc_chain_check
  import rvfi_pc_chain_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NRET  = 1,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       check,
  input  logic [63:0]                base_order,
  input  logic [NRET-1:0]            rvfi_valid,
  input  logic [64*NRET-1:0]         rvfi_order,
  input  logic [XLEN*NRET-1:0]       rvfi_pc_rdata,
  input  logic [XLEN*NRET-1:0]       rvfi_pc_wdata,
  input  logic [NRET-1:0]            rvfi_trap,
  input  logic [NRET-1:0]            rvfi_intr,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic                       err_dup,
  output logic [$clog2(DEPTH)-1:0]   err_pair
);

  localparam int IW = $clog2(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] rdata;
    logic [XLEN-1:0] wdata;
`ifdef RVFI_PC_CHAIN_TRAP_SKIP_EN
    logic            trap;
    logic            intr;
`endif
  } slot_t;

  chain_state_e           state_q, state_d;
  logic [63:0]            base_q, base_d;
  logic [DEPTH-1:0]       sv_q, sv_d;
  slot_t [DEPTH-1:0]      slot_q, slot_d;
  logic [DEPTH-2:0]       chk_q, chk_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   dup_q, dup_d;
  logic [IW-1:0]          pair_q, pair_d;

  logic [DEPTH-1:0]            we;
  logic [DEPTH-1:0][XLEN-1:0]  wr_rdata, wr_wdata;
  logic [DEPTH-1:0]            wr_trap, wr_intr;
  logic                        dup;
  logic [IW-1:0]               dup_idx;
  logic [DEPTH-2:0]            rdy, mm;
  logic [IW-1:0]               mm_idx;

  rvfi_pc_chain_capture #(
    .XLEN (XLEN),
    .NRET (NRET),
    .DEPTH(DEPTH),
    .IW   (IW)
  ) u_capture (
    .en      (state_q == COLLECT),
    .base    (base_q),
    .slot_vld(sv_q),
    .valid   (rvfi_valid),
    .order   (rvfi_order),
    .rdata   (rvfi_pc_rdata),
    .wdata   (rvfi_pc_wdata),
    .trap    (rvfi_trap),
    .intr    (rvfi_intr),
    .we      (we),
    .wr_rdata(wr_rdata),
    .wr_wdata(wr_wdata),
    .wr_trap (wr_trap),
    .wr_intr (wr_intr),
    .dup     (dup),
    .dup_idx (dup_idx)
  );

`ifndef RVFI_PC_CHAIN_TRAP_SKIP_EN
  logic unused_flags;
  assign unused_flags = ^{wr_trap, wr_intr};
`endif

  // Pair compare works on registered slots, one cycle behind capture
  always_comb begin
    rdy    = '0;
    mm     = '0;
    mm_idx = '0;
    for (int k = 0; k < DEPTH - 1; k++) begin
      rdy[k] = sv_q[k] & sv_q[k+1] & ~chk_q[k];
      mm[k]  = rdy[k] && (slot_q[k].wdata != slot_q[k+1].rdata);
`ifdef RVFI_PC_CHAIN_TRAP_SKIP_EN
      if (slot_q[k].trap || slot_q[k+1].intr) mm[k] = 1'b0;
`endif
    end
    for (int k = DEPTH - 2; k >= 0; k--) begin
      if (mm[k]) mm_idx = IW'(k);
    end
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    sv_d    = sv_q;
    slot_d  = slot_q;
    chk_d   = chk_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    dup_d   = dup_q;
    pair_d  = pair_q;
    if (!check) begin
      state_d = IDLE;
      sv_d    = '0;
      chk_d   = '0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      dup_d   = 1'b0;
      pair_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          base_d  = base_order;
          state_d = COLLECT;
          busy_d  = 1'b1;
        end
        COLLECT: begin
          for (int s = 0; s < DEPTH; s++) begin
            if (we[s]) begin
              sv_d[s]         = 1'b1;
              slot_d[s].rdata = wr_rdata[s];
              slot_d[s].wdata = wr_wdata[s];
`ifdef RVFI_PC_CHAIN_TRAP_SKIP_EN
              slot_d[s].trap  = wr_trap[s];
              slot_d[s].intr  = wr_intr[s];
`endif
            end
          end
          chk_d = chk_q | rdy;
          if (dup) begin
            state_d = FAIL;
            busy_d  = 1'b0;
            err_d   = 1'b1;
            dup_d   = 1'b1;
            pair_d  = dup_idx;
          end else if (|mm) begin
            state_d = FAIL;
            busy_d  = 1'b0;
            err_d   = 1'b1;
            pair_d  = mm_idx;
          end else if (&sv_q && &(chk_q | rdy)) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      base_q  <= '0;
      sv_q    <= '0;
      slot_q  <= '0;
      chk_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      dup_q   <= 1'b0;
      pair_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      sv_q    <= sv_d;
      slot_q  <= slot_d;
      chk_q   <= chk_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      dup_q   <= dup_d;
      pair_q  <= pair_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign err_dup  = dup_q;
  assign err_pair = pair_q;

`ifdef FORMAL
  always @(posedge clock) begin
    if (!reset) assert (!err_q);
  end
  if (NRET > 1) begin : g_uniq
    for (genvar i = 0; i < NRET; i++) begin : g_i
      for (genvar j = i + 1; j < NRET; j++) begin : g_j
        always_comb assume (!(rvfi_valid[i] && rvfi_valid[j]) ||
          rvfi_order[64*i +: 64] != rvfi_order[64*j +: 64]);
      end
    end
  end
`endif

endmodule

// File: tb/tb_rvfi_pc_chain_check.sv
// Scoreboard bench for rvfi_pc_chain_check (NRET=2, DEPTH=4).
// Expected results come from a window model of retired instructions.
module tb_rvfi_pc_chain_check;

  localparam int XLEN  = 32;
  localparam int NRET  = 2;
  localparam int DEPTH = 4;
  localparam int IW    = 2;

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  check;
  logic [63:0]           base_order;
  logic [NRET-1:0]       rvfi_valid, rvfi_trap, rvfi_intr;
  logic [64*NRET-1:0]    rvfi_order;
  logic [XLEN*NRET-1:0]  rvfi_pc_rdata, rvfi_pc_wdata;
  logic                  busy, done, err, err_dup;
  logic [IW-1:0]         err_pair;

  rvfi_pc_chain_check #(.XLEN(XLEN), .NRET(NRET), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .check(check), .base_order(base_order),
    .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
    .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
    .rvfi_trap(rvfi_trap), .rvfi_intr(rvfi_intr),
    .busy(busy), .done(done), .err(err), .err_dup(err_dup),
    .err_pair(err_pair)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int          cy;
    logic [63:0] ord;
    logic [31:0] rd;
    logic [31:0] wd;
    logic        tr;
    logic        in;
  } ret_t;

  typedef struct {
    logic          done;
    logic          err;
    logic          dup;
    logic [IW-1:0] pair;
    int            at;
  } exp_t;

  ret_t sched[$];
  exp_t expq[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, want);
    end
  endtask

  task automatic add(input int cy, input logic [63:0] o, input logic [31:0] rd,
                     input logic [31:0] wd, input logic tr, input logic in);
    ret_t r;
    r.cy = cy; r.ord = o; r.rd = rd; r.wd = wd; r.tr = tr; r.in = in;
    sched.push_back(r);
  endtask

  // order base+i in a straight-line chain starting at PC 0x100
  task automatic addi(input int cy, input int i, input logic [63:0] base);
    logic [31:0] pc;
    pc = 32'h100 + 32'(4 * i);
    add(cy, base + 64'(i), pc, pc + 32'd4, 1'b0, 1'b0);
  endtask

  function automatic int cnt_at(input int cy);
    int n = 0;
    foreach (sched[i]) if (sched[i].cy == cy) n++;
    return n;
  endfunction

  task automatic drive(input int j);
    int ch = 0;
    rvfi_valid = '0; rvfi_order = '0; rvfi_trap = '0; rvfi_intr = '0;
    rvfi_pc_rdata = '0; rvfi_pc_wdata = '0;
    foreach (sched[i]) begin
      if (sched[i].cy == j && ch < NRET) begin
        rvfi_valid[ch]               = 1'b1;
        rvfi_order[64*ch +: 64]      = sched[i].ord;
        rvfi_pc_rdata[XLEN*ch +: XLEN] = sched[i].rd;
        rvfi_pc_wdata[XLEN*ch +: XLEN] = sched[i].wd;
        rvfi_trap[ch]                = sched[i].tr;
        rvfi_intr[ch]                = sched[i].in;
        ch++;
      end
    end
  endtask

  // Called at posedge+1; the next edge arms the checker with base.
  task automatic run_txn(input logic [63:0] base);
    bit          mv[DEPTH];
    logic [31:0] mrd[DEPTH];
    logic [31:0] mwd[DEPTH];
    bit          mtr[DEPTH];
    bit          mi[DEPTH];
    exp_t        last_e;
    int          last = 0;
    bit          fin = 0;
    foreach (mv[o]) begin mv[o] = 0; mtr[o] = 0; mi[o] = 0; end
    foreach (sched[i]) if (sched[i].cy > last) last = sched[i].cy;
    check = 1'b1;
    base_order = base;
    drive(0);
    @(posedge clock); #1;
    chk("busy_after_arm", 64'(busy), 64'd1);
    for (int j = 1; j <= last + 3 && !fin; j++) begin
      bit   hit[DEPTH];
      int   dmin = -1;
      int   kmin = -1;
      bit   full = 1;
      exp_t e;
      foreach (hit[o]) hit[o] = 0;
      drive(j);
      foreach (sched[i]) begin
        logic [63:0] off;
        off = sched[i].ord - base;
        if (sched[i].cy == j && off < 64'(DEPTH)) begin
          if ((mv[int'(off)] || hit[int'(off)]) && (dmin < 0 || int'(off) < dmin))
            dmin = int'(off);
          hit[int'(off)] = 1;
        end
      end
      for (int k = 0; k < DEPTH - 1; k++) begin
        bit ex = 0;
`ifdef RVFI_PC_CHAIN_TRAP_SKIP_EN
        ex = mtr[k] || mi[k+1];
`endif
        if (kmin < 0 && mv[k] && mv[k+1] && mwd[k] != mrd[k+1] && !ex) kmin = k;
      end
      foreach (mv[o]) if (!mv[o]) full = 0;
      e.done = 0; e.err = 0; e.dup = 0; e.pair = '0; e.at = cyc + 1;
      if (dmin >= 0) begin
        e.err = 1; e.dup = 1; e.pair = IW'(dmin); fin = 1;
      end else if (kmin >= 0) begin
        e.err = 1; e.pair = IW'(kmin); fin = 1;
      end else if (full) begin
        e.done = 1; fin = 1;
      end
      if (fin) begin
        expq.push_back(e);
        last_e = e;
      end else begin
        foreach (sched[i]) begin
          logic [63:0] off;
          off = sched[i].ord - base;
          if (sched[i].cy == j && off < 64'(DEPTH)) begin
            mv[int'(off)]  = 1;
            mrd[int'(off)] = sched[i].rd;
            mwd[int'(off)] = sched[i].wd;
            mtr[int'(off)] = sched[i].tr;
            mi[int'(off)]  = sched[i].in;
          end
        end
      end
      @(posedge clock); #1;
    end
    drive(-1);
    if (!fin) begin
      n_chk++; n_fail++;
      $display("FAIL model_no_outcome: base 0x%0h", base);
    end
    for (int t = 0; t < 10 && expq.size() > 0; t++) @(posedge clock);
    if (expq.size() > 0) begin
      n_chk++; n_fail++;
      $display("FAIL result_timeout: %0d results never seen", expq.size());
      expq.delete();
    end
    repeat (2) @(posedge clock);
    #1;
    if (fin) begin
      chk("hold_done", 64'(done), 64'(last_e.done));
      chk("hold_err", 64'(err), 64'(last_e.err));
    end
    check = 1'b0;
    @(posedge clock); #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_err", 64'(err), 64'd0);
    chk("abort_dup", 64'(err_dup), 64'd0);
    chk("abort_pair", 64'(err_pair), 64'd0);
    sched.delete();
  endtask

  task automatic build_rand(output logic [63:0] base);
    logic [31:0] pc[DEPTH+1];
    logic [31:0] wd[DEPTH];
    bit          tr[DEPTH];
    bit          in[DEPTH];
    int          perm[DEPTH];
    int          cy = 1;
    int          n = 0;
    int          mode, k, c2;
    base = {$urandom, $urandom};
    if ($urandom_range(0, 3) == 0)
      base = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 4));
    pc[0] = $urandom & 32'hFFFF_FFFC;
    for (int i = 0; i < DEPTH; i++)
      pc[i+1] = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFFC) : pc[i] + 32'd4;
    for (int i = 0; i < DEPTH; i++) begin
      wd[i] = pc[i+1]; tr[i] = 0; in[i] = 0; perm[i] = i;
    end
    mode = $urandom_range(0, 3);
    k = $urandom_range(0, DEPTH - 2);
    if (mode == 1) wd[k] ^= 32'h40;
    if (mode == 3) begin
      wd[k] ^= 32'h80;
      if ($urandom_range(0, 1) == 1) tr[k] = 1; else in[k+1] = 1;
    end
    for (int i = DEPTH - 1; i > 0; i--) begin
      int r, t;
      r = $urandom_range(0, i);
      t = perm[i]; perm[i] = perm[r]; perm[r] = t;
    end
    foreach (perm[p]) begin
      int i;
      i = perm[p];
      if (n == NRET || (n > 0 && $urandom_range(0, 1) == 1)) begin
        cy += $urandom_range(1, 2);
        n = 0;
      end
      add(cy, base + 64'(i), pc[i], wd[i], tr[i], in[i]);
      n++;
    end
    if (mode == 2) begin
      int i;
      i = perm[$urandom_range(0, DEPTH - 1)];
      c2 = $urandom_range(1, cy);
      if (cnt_at(c2) >= NRET) c2 = cy + 1;
      add(c2, base + 64'(i), pc[i], wd[i], tr[i], in[i]);
    end
    if ($urandom_range(0, 1) == 1) begin
      c2 = $urandom_range(1, cy);
      if (cnt_at(c2) < NRET)
        add(c2, ($urandom_range(0, 1) == 1) ? base + 64'(DEPTH + $urandom_range(0, 50))
                                            : base - 64'(1 + $urandom_range(0, 50)),
            $urandom, $urandom, 1'b0, 1'b0);
    end
    if ($urandom_range(0, 1) == 1)
      add(0, base + 64'($urandom_range(0, DEPTH - 1)), $urandom, $urandom, 1'b0, 1'b0);
  endtask

  initial begin : mon
    exp_t e;
    bit   rpt = 0;
    forever begin
      @(negedge clock);
      if (reset || !(done || err)) begin
        rpt = 0;
      end else if (!rpt) begin
        rpt = 1;
        if (expq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_result: done=%0b err=%0b at cycle %0d", done, err, cyc);
        end else begin
          e = expq.pop_front();
          chk("res_cycle", 64'(cyc), 64'(e.at));
          chk("res_done", 64'(done), 64'(e.done));
          chk("res_err", 64'(err), 64'(e.err));
          chk("res_dup", 64'(err_dup), 64'(e.dup));
          chk("res_pair", 64'(err_pair), 64'(e.pair));
          chk("res_busy", 64'(busy), 64'd0);
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [63:0] b;
    reset = 1'b1;
    check = 1'b0;
    base_order = '0;
    drive(-1);
    repeat (2) @(posedge clock);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_dup", 64'(err_dup), 64'd0);
    chk("rst_pair", 64'(err_pair), 64'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    b = 64'd10;
    for (int i = 0; i < DEPTH; i++) addi(i + 1, i, b);
    run_txn(b);

    addi(1, 1, b); addi(1, 0, b); addi(2, 3, b); addi(2, 2, b);
    add(0, b + 64'd2, 32'hDEAD_0000, 32'hBEEF_0000, 1'b0, 1'b0);
    run_txn(b);

    for (int i = 0; i < DEPTH; i++) addi(i + 1, i, b);
    sched[1].wd = 32'h200;
    run_txn(b);

    addi(1, 0, b); addi(2, 1, b); addi(3, 2, b); addi(4, 2, b);
    run_txn(b);

    b = 64'hFFFF_FFFF_FFFF_FFFE;
    for (int i = 0; i < DEPTH; i++) addi(i + 1, i, b);
    run_txn(b);

    b = 64'd10;
    for (int i = 0; i < DEPTH; i++) addi(i + 1, i, b);
    sched[1].wd = 32'h200;
    sched[1].tr = 1'b1;
    run_txn(b);

    // reset in COLLECT with a filled slot; check stays high across it
    check = 1'b1;
    base_order = b;
    @(posedge clock); #1;
    addi(0, 0, b);
    drive(0);
    sched.delete();
    @(posedge clock); #1;
    drive(-1);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_err", 64'(err), 64'd0);
    chk("midrst_dup", 64'(err_dup), 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) addi(i + 1, i, b);
    run_txn(b);

    repeat (60) begin
      build_rand(b);
      run_txn(b);
    end

    repeat (3) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
